// File: rtl/display_scan_reader.sv
// ============================================================================
// Module   : display_scan_reader
// Purpose  : Receive end of a multiplexed 4-digit 7-segment display bus.
//            Synchronises the anode/segment lines, waits for each scanned
//            digit to sit still for STABLE_CYCLES samples, decodes its
//            segment pattern and publishes a 4-digit frame once every digit
//            has been seen.
// Ports    : clk          system clock
//            rst_n        asynchronous reset, active-low
//            s1[3:0]      anode selects, active-low one-hot (bit n = digit n)
//            d7[6:0]      segments, active-low, d7[6]=a ... d7[0]=g
//            code0..3     decoded digit codes, updated with frame_valid
//            frame_valid  one-cycle pulse, code0..3 hold a new frame
//            err_cnt[7:0] saturating count of accepts that decoded invalid
//                         (only when DISPLAY_READER_ERRCNT_EN is defined)
//            stale        no digit accepted for >= TIMEOUT cycles
// Options  : `define DISPLAY_READER_ERRCNT_EN adds the err_cnt port/counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1024,
  parameter int CNT_W         = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] s1,
  input  logic [6:0] d7,
  output logic [4:0] code0,
  output logic [4:0] code1,
  output logic [4:0] code2,
  output logic [4:0] code3,
  output logic       frame_valid,
`ifdef DISPLAY_READER_ERRCNT_EN
  output logic [7:0] err_cnt,
`endif
  output logic       stale
);

  localparam logic [4:0]       c_BLANK     = 5'd18;
  localparam logic [4:0]       c_INVALID   = 5'd31;
  // Equal-sample comparisons needed after the first sample of a digit.
  localparam logic [CNT_W-1:0] c_STAB_LAST = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] c_TIMEOUT   = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  function automatic logic [4:0] f_decode(input logic [6:0] seg);
    logic [4:0] code;
    case (seg)
      7'b0000001: code = 5'd0;
      7'b1001111: code = 5'd1;
      7'b0010010: code = 5'd2;
      7'b0000110: code = 5'd3;
      7'b1001100: code = 5'd4;
      7'b0100100: code = 5'd5;
      7'b0100000: code = 5'd6;
      7'b0001111: code = 5'd7;
      7'b0000000: code = 5'd8;
      7'b0000100: code = 5'd9;
      7'b0001000: code = 5'd10;
      7'b1100000: code = 5'd11;
      7'b0110001: code = 5'd12;
      7'b1000010: code = 5'd13;
      7'b0110000: code = 5'd14;
      7'b0111000: code = 5'd15;
      7'b1100010: code = 5'd16;
      7'b1110001: code = 5'd17;
      7'b1111111: code = c_BLANK;
      default:    code = c_INVALID;
    endcase
    return code;
  endfunction

  // Two-flop synchronisers
  logic [3:0]       r_s1_m, r_s1_s;
  logic [6:0]       r_d7_m, r_d7_s;
  logic [10:0]      r_prev;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_stab_cnt, w_stab_nxt;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [3:0]       r_seen, w_seen_base;
  logic [4:0]       r_shadow [4];
  logic [4:0]       r_code   [4];
  logic             r_frame_valid;

  logic             w_sel_ok;
  logic [1:0]       w_idx;
  logic [4:0]       w_code;
  logic             w_same;
  logic             w_accept;
  logic             w_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_m <= 4'hF;
      r_s1_s <= 4'hF;
      r_d7_m <= 7'h7F;
      r_d7_s <= 7'h7F;
      r_prev <= 11'h7FF;
    end else begin
      r_s1_m <= s1;
      r_s1_s <= r_s1_m;
      r_d7_m <= d7;
      r_d7_s <= r_d7_m;
      r_prev <= {r_s1_s, r_d7_s};
    end
  end

  always_comb begin
    w_sel_ok = 1'b1;
    w_idx    = 2'd0;
    case (r_s1_s)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_sel_ok = 1'b0;
    endcase
    w_code = f_decode(r_d7_s);
    w_same = ({r_s1_s, r_d7_s} == r_prev);
  end

  // Next-state logic. The sample seen on entry to WAIT counts as the first
  // identical sample, so an accept needs STABLE_CYCLES-1 further matches.
  always_comb begin
    w_state_nxt = r_state;
    w_stab_nxt  = r_stab_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stab_nxt = '0;
        if (w_sel_ok) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!w_sel_ok) begin
          w_state_nxt = S_IDLE;
          w_stab_nxt  = '0;
        end else if (!w_same) begin
          w_stab_nxt = '0;
        end else if (r_stab_cnt == c_STAB_LAST) begin
          w_accept    = 1'b1;
          w_state_nxt = S_HOLD;
          w_stab_nxt  = '0;
        end else begin
          w_stab_nxt = r_stab_cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        w_stab_nxt = '0;
        if (!w_same) w_state_nxt = w_sel_ok ? S_WAIT : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_stab_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_stab_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_nxt;
    end
  end

  // A complete seen mask publishes next cycle; an accept in that cycle
  // survives the clear and starts the following frame.
  assign w_frame     = (r_seen == 4'hF);
  assign w_seen_base = w_frame ? 4'h0 : r_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= c_BLANK;
        r_code[i]   <= c_BLANK;
      end
      r_seen        <= 4'h0;
      r_frame_valid <= 1'b0;
      r_idle_cnt    <= '0;
    end else begin
      r_frame_valid <= w_frame;
      if (w_frame) begin
        for (int i = 0; i < 4; i++) r_code[i] <= r_shadow[i];
      end
      if (w_accept) begin
        r_shadow[w_idx] <= w_code;
        r_seen          <= w_seen_base | ~r_s1_s;
        r_idle_cnt      <= '0;
      end else begin
        r_seen <= w_seen_base;
        if (r_idle_cnt != c_TIMEOUT) r_idle_cnt <= r_idle_cnt + CNT_W'(1);
      end
    end
  end

`ifdef DISPLAY_READER_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_accept && (w_code == c_INVALID) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign code0       = r_code[0];
  assign code1       = r_code[1];
  assign code2       = r_code[2];
  assign code3       = r_code[3];
  assign frame_valid = r_frame_valid;
  assign stale       = (r_idle_cnt == c_TIMEOUT);

endmodule

`default_nettype wire

// File: tb/tb_display_scan_reader.sv
// ============================================================================
// Module   : tb_display_scan_reader
// Purpose  : Self-checking bench for display_scan_reader. Expected frames are
//            queued as scans are driven and compared when frame_valid fires.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_scan_reader;

  localparam int TIMEOUT = 1024;

  logic       clk;
  logic       rst_n;
  logic [3:0] s1;
  logic [6:0] d7;
  logic [4:0] code0, code1, code2, code3;
  logic       frame_valid;
  logic       stale;
`ifdef DISPLAY_READER_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  logic [19:0] exp_q[$];

  display_scan_reader #(
    .STABLE_CYCLES(4),
    .TIMEOUT      (TIMEOUT),
    .CNT_W        (11)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s1         (s1),
    .d7         (d7),
    .code0      (code0),
    .code1      (code1),
    .code2      (code2),
    .code3      (code3),
    .frame_valid(frame_valid),
`ifdef DISPLAY_READER_ERRCNT_EN
    .err_cnt    (err_cnt),
`endif
    .stale      (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_code0"}, 32'(code0), 32'd18);
    check({tag, "_code1"}, 32'(code1), 32'd18);
    check({tag, "_code2"}, 32'(code2), 32'd18);
    check({tag, "_code3"}, 32'(code3), 32'd18);
    check({tag, "_fv"},    32'(frame_valid), 32'd0);
    check({tag, "_stale"}, 32'(stale), 32'd0);
  endtask

  // Called at a negedge; leaves the bus driven for n cycles.
  task automatic drive(input logic [3:0] s, input logic [6:0] d, input int n);
    s1 = s;
    d7 = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_pass(input logic [6:0] p0, input logic [6:0] p1,
                           input logic [6:0] p2, input logic [6:0] p3,
                           input logic [4:0] e0, input logic [4:0] e1,
                           input logic [4:0] e2, input logic [4:0] e3);
    exp_q.push_back({e3, e2, e1, e0});
    drive(4'b1110, p0, 8);
    drive(4'b1101, p1, 8);
    drive(4'b1011, p2, 8);
    drive(4'b0111, p3, 8);
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("frame_code0", 32'(code0), 32'(e[4:0]));
        check("frame_code1", 32'(code1), 32'(e[9:5]));
        check("frame_code2", 32'(code2), 32'(e[14:10]));
        check("frame_code3", 32'(code3), 32'(e[19:15]));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    s1    = 4'hF;
    d7    = 7'h7F;
    repeat (3) @(negedge clk);
    check_blank("reset");
`ifdef DISPLAY_READER_ERRCNT_EN
    check("reset_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_blank("idle");

    // Basic scan, repeated: one frame per full pass
    scan_pass(7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 5'd0, 5'd1, 5'd2, 5'd3);
    scan_pass(7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 5'd0, 5'd1, 5'd2, 5'd3);

    // Re-accepting digit 0 within a frame overwrites it (0 then 5)
    exp_q.push_back({5'd3, 5'd2, 5'd1, 5'd5});
    drive(4'b1110, 7'b0000001, 8);
    drive(4'b1110, 7'b0100100, 8);
    drive(4'b1101, 7'b1001111, 8);
    drive(4'b1011, 7'b0010010, 8);
    drive(4'b0111, 7'b0000110, 8);

    // 8, o, blank, L
    scan_pass(7'b0000000, 7'b1100010, 7'b1111111, 7'b1110001, 5'd8, 5'd16, 5'd18, 5'd17);
    repeat (4) @(negedge clk);

    // Glitching segments never settle long enough to accept
    s1 = 4'b1110;
    for (int i = 0; i < 12; i++) begin
      d7 = i[0] ? 7'b1001111 : 7'b0000001;
      repeat (2) @(negedge clk);
    end
    drive(4'b1100, 7'b0000001, 20);

    // Partial frame: digits 1..3 only, must not publish on their own
    drive(4'b1101, 7'b1001100, 8);
    drive(4'b1011, 7'b0100000, 8);
    drive(4'b0111, 7'b0001111, 8);

    // Stop scanning
    drive(4'b1111, 7'h7F, 100);
    check("stale_early", 32'(stale), 32'd0);
    drive(4'b1111, 7'h7F, TIMEOUT + 5);
    check("stale_set", 32'(stale), 32'd1);

    // Resume with digit 0: seen mask survived stale, so this completes a frame
    exp_q.push_back({5'd7, 5'd6, 5'd4, 5'd9});
    s1 = 4'b1110;
    d7 = 7'b0000100;
    repeat (5) @(posedge clk);
    #1 check("stale_before_accept", 32'(stale), 32'd1);
    @(posedge clk);
    #1 check("stale_cleared", 32'(stale), 32'd0);
    repeat (4) @(negedge clk);
    drive(4'b1111, 7'h7F, 6);

    // Invalid pattern on digit 2 is published as 31
    scan_pass(7'b0000001, 7'b1001111, 7'b0101010, 7'b0000110, 5'd0, 5'd1, 5'd31, 5'd3);
    repeat (4) @(negedge clk);
`ifdef DISPLAY_READER_ERRCNT_EN
    check("err_cnt_one", 32'(err_cnt), 32'd1);
`endif

    // Reset mid-frame
    drive(4'b1110, 7'b0000110, 8);
    drive(4'b1101, 7'b1001111, 4);
    #3 rst_n = 1'b0;
    #1 check_blank("mid_reset");
`ifdef DISPLAY_READER_ERRCNT_EN
    check("mid_reset_err_cnt", 32'(err_cnt), 32'd0);
`endif
    @(negedge clk);
    drive(4'b1111, 7'h7F, 2);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Digit 0 from before reset must be forgotten: 1..3 alone do not publish
    drive(4'b1101, 7'b1001111, 8);
    drive(4'b1011, 7'b0010010, 8);
    drive(4'b0111, 7'b0000110, 8);
    drive(4'b1111, 7'h7F, 4);
    check("post_reset_code0", 32'(code0), 32'd18);
    check("post_reset_fv", 32'(frame_valid), 32'd0);

    exp_q.push_back({5'd3, 5'd2, 5'd1, 5'd8});
    drive(4'b1110, 7'b0000000, 8);
    drive(4'b1111, 7'h7F, 10);

    check("frames_outstanding", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
